// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation bundle, datapath width and function-select encodings.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic       MODE_LOGIC = 1'b1;
    localparam logic       MODE_ARITH = 1'b0;

    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_XOR    = 4'b0110;
    localparam logic [3:0] SEL_PASS_A = 4'b1111;

    typedef struct packed {
        logic             mode;
        logic [3:0]       sel;
        logic             carry_in;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } alu_op_t;

endpackage

// File: rtl/rr_grant.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_grant #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                grant_idx                  = IDW'((int'(ptr) + k) % N);
                any                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU core among NUM_REQ requesters with round-robin grant,
// a lock/chain mode for multi-word carry propagation, and a one-entry response register.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = ALU_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_mode,
    input  logic [4*NUM_REQ-1:0]       req_sel,
    input  logic [NUM_REQ-1:0]         req_carry_in,
    input  logic [NUM_REQ-1:0]         req_chain,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [W*NUM_REQ-1:0]       req_a,
    input  logic [W*NUM_REQ-1:0]       req_b,
    output logic                       alu_mode,
    output logic [3:0]                 alu_sel,
    output logic                       alu_carry_in,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    input  logic [W-1:0]               alu_out,
    input  logic                       alu_carry_out,
    input  logic                       alu_compare,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [W-1:0]               rsp_data,
    output logic                       rsp_carry,
    output logic                       rsp_compare
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     lock_id;
    logic               stored_carry;

    logic [NUM_REQ-1:0] eligible;
    logic [IDW-1:0]     pick_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               any_grant;
    logic [IDW-1:0]     src_idx;
    logic [IDW-1:0]     ptr_next;
    logic               can_issue;
    logic               issue;
    alu_op_t            op;

    // Handshakes are strict valid/ready: a request transfers in a cycle where both
    // req_valid[i] and req_ready[i] are high; a response transfers when rsp_valid and
    // rsp_ready are both high. req_ready never depends on req_ready/rsp_valid of the same
    // requester combinationally beyond can_issue, so drain and issue may coincide.
    assign can_issue = !rsp_valid || rsp_ready;

    // While locked, only the lock holder competes, even when it is idle.
    assign eligible = (state == ST_LOCKED)
                    ? (req_valid & (NUM_REQ'(1) << lock_id))
                    : req_valid;
    assign pick_ptr = (state == ST_LOCKED) ? lock_id : rr_ptr;

    rr_grant #(.N(NUM_REQ), .IDW(IDW)) u_rr_grant (
        .req       (eligible),
        .ptr       (pick_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_grant)
    );

    assign issue     = any_grant && can_issue;
    assign req_ready = issue ? grant : '0;
    assign src_idx   = any_grant ? grant_idx : rr_ptr;
    assign ptr_next  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        op          = '0;
        op.mode     = req_mode[src_idx];
        op.sel      = req_sel[4*src_idx +: 4];
        op.carry_in = req_chain[src_idx] ? stored_carry : req_carry_in[src_idx];
        op.a        = req_a[W*src_idx +: W];
        op.b        = req_b[W*src_idx +: W];
    end

    assign alu_mode     = op.mode;
    assign alu_sel      = op.sel;
    assign alu_carry_in = op.carry_in;
    assign alu_a        = op.a;
    assign alu_b        = op.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ARB;
            rr_ptr       <= '0;
            lock_id      <= '0;
            stored_carry <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_carry    <= 1'b0;
            rsp_compare  <= 1'b0;
        end else if (issue) begin
            state        <= req_lock[grant_idx] ? ST_LOCKED : ST_ARB;
            rr_ptr       <= ptr_next;
            lock_id      <= grant_idx;
            stored_carry <= alu_carry_out;
            rsp_valid    <= 1'b1;
            rsp_id       <= grant_idx;
            rsp_data     <= alu_out;
            rsp_carry    <= alu_carry_out;
            rsp_compare  <= alu_compare;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural ALU core attached.
module tb_alu_issue_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_mode = '0;
  logic [4*NUM_REQ-1:0] req_sel = '0;
  logic [NUM_REQ-1:0] req_carry_in = '0;
  logic [NUM_REQ-1:0] req_chain = '0;
  logic [NUM_REQ-1:0] req_lock = '0;
  logic [W*NUM_REQ-1:0] req_a = '0;
  logic [W*NUM_REQ-1:0] req_b = '0;
  logic alu_mode;
  logic [3:0] alu_sel;
  logic alu_carry_in;
  logic [W-1:0] alu_a, alu_b;
  logic [W-1:0] alu_out;
  logic alu_carry_out;
  logic alu_compare;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [0:0] rsp_id;
  logic [W-1:0] rsp_data;
  logic rsp_carry;
  logic rsp_compare;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_sel(req_sel), .req_carry_in(req_carry_in), .req_chain(req_chain),
    .req_lock(req_lock), .req_a(req_a), .req_b(req_b),
    .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_carry_in(alu_carry_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_compare(rsp_compare)
  );

  // Behavioural ALU core: arithmetic add with carry, logic XOR and pass-A.
  always_comb begin
    alu_out = '0;
    alu_carry_out = 1'b0;
    alu_compare = (alu_a == alu_b);
    if (alu_mode == MODE_ARITH && alu_sel == SEL_ADD)
      {alu_carry_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_carry_in};
    else if (alu_mode == MODE_LOGIC && alu_sel == SEL_XOR)
      alu_out = alu_a ^ alu_b;
    else if (alu_mode == MODE_LOGIC && alu_sel == SEL_PASS_A)
      alu_out = alu_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic mode, input logic [3:0] sel,
                         input logic cin, input logic chain, input logic lock,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = v;
    req_mode[i] = mode;
    req_sel[4*i +: 4] = sel;
    req_carry_in[i] = cin;
    req_chain[i] = chain;
    req_lock[i] = lock;
    req_a[W*i +: W] = a;
    req_b[W*i +: W] = b;
  endtask

  task automatic clear_reqs();
    set_req(0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    // Leave req0 locked and rr_ptr at 1 with a held response, then reset mid-cycle.
    set_req(0, 1'b1, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0003);
    rsp_ready = 1'b0;
    tick();
    clear_reqs();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b want=1", rsp_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", rsp_data); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%h want=0", rsp_id); end
    total++; if (rsp_carry !== 1'b0 || rsp_compare !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", rsp_carry, rsp_compare); end
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(1, 1'b1, MODE_LOGIC, SEL_PASS_A, 1'b0, 1'b0, 1'b0, 16'h0777, 16'h0);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL reset_lock_dropped got=%b want=10", req_ready); end
    set_req(0, 1'b1, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0020);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b want=01", req_ready); end
    tick();
    clear_reqs();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0030) begin
      bad++; $display("FAIL reset_first_rsp got=%b/%h/%h want=1/0/0030", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_single_op();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0001);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", req_ready); end
    tick();
    clear_reqs();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL single_id got=%h want=0", rsp_id); end
    total++; if (rsp_data !== 16'h1235 || rsp_carry !== 1'b0) begin
      bad++; $display("FAIL single_data got=%h/%b want=1235/0", rsp_data, rsp_carry); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", rsp_valid); end
  endtask

  // rr_ptr is 1 here (last grant went to 0), so the alternation starts at requester 1.
  task automatic test_fairness();
    logic [0:0] exp_id;
    logic [W-1:0] exp_data;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, MODE_LOGIC, SEL_XOR, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0F0F);
    set_req(1, 1'b1, MODE_LOGIC, SEL_PASS_A, 1'b0, 1'b0, 1'b0, 16'hABCD, 16'h1111);
    exp_id = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++; if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL fair_ready[%0d] got=%b want_id=%0d", n, req_ready, exp_id); end
      tick();
      exp_data = exp_id ? 16'hABCD : 16'h0FF0;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin
        bad++; $display("FAIL fair_rsp[%0d] got=%b/%h/%h want=1/%h/%h", n, rsp_valid, rsp_id, rsp_data, exp_id, exp_data); end
      exp_id = ~exp_id;
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=00", n, req_ready); end
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h0FF0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%h want=1/0/0ff0", n, rsp_valid, rsp_id, rsp_data); end
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_release_ready got=%b want=10", req_ready); end
    tick();
    clear_reqs();
    total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'hABCD) begin
      bad++; $display("FAIL bp_release_rsp got=%b/%h/%h want=1/1/abcd", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_chain();
    rsp_ready = 1'b1;
    // Move rr_ptr to 1 so requester 1 wins the first arbitration below.
    set_req(0, 1'b1, MODE_LOGIC, SEL_PASS_A, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0);
    tick();
    total++; if (rsp_id !== 1'b0 || rsp_data !== 16'h0042) begin
      bad++; $display("FAIL chain_setup got=%h/%h want=0/0042", rsp_id, rsp_data); end
    set_req(0, 1'b1, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001);
    set_req(1, 1'b1, MODE_ARITH, SEL_ADD, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL chain_lo_ready got=%b want=10", req_ready); end
    tick();
    total++; if (rsp_id !== 1'b1 || rsp_data !== 16'h0000 || rsp_carry !== 1'b1) begin
      bad++; $display("FAIL chain_lo_rsp got=%h/%h/%b want=1/0000/1", rsp_id, rsp_data, rsp_carry); end
    set_req(1, 1'b1, MODE_ARITH, SEL_ADD, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL chain_hi_ready got=%b want=10", req_ready); end
    total++; if (alu_carry_in !== 1'b1) begin bad++; $display("FAIL chain_cin got=%b want=1", alu_carry_in); end
    tick();
    total++; if (rsp_id !== 1'b1 || rsp_data !== 16'h0001 || rsp_carry !== 1'b0) begin
      bad++; $display("FAIL chain_hi_rsp got=%h/%h/%b want=1/0001/0", rsp_id, rsp_data, rsp_carry); end
    set_req(1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL chain_unlock_ready got=%b want=01", req_ready); end
    tick();
    clear_reqs();
    total++; if (rsp_id !== 1'b0 || rsp_data !== 16'h0002) begin
      bad++; $display("FAIL chain_after_rsp got=%h/%h want=0/0002", rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_lock_idle();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, MODE_LOGIC, SEL_PASS_A, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0);
    set_req(1, 1'b1, MODE_LOGIC, SEL_XOR, 1'b0, 1'b0, 1'b1, 16'hF0F0, 16'hFFFF);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL idle_lock_ready got=%b want=10", req_ready); end
    tick();
    total++; if (rsp_id !== 1'b1 || rsp_data !== 16'h0F0F) begin
      bad++; $display("FAIL idle_lock_rsp got=%h/%h want=1/0f0f", rsp_id, rsp_data); end
    req_valid[1] = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL idle_blocked[%0d] got=%b want=00", n, req_ready); end
      tick();
    end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_no_rsp got=%b want=0", rsp_valid); end
    set_req(1, 1'b1, MODE_LOGIC, SEL_PASS_A, 1'b0, 1'b0, 1'b0, 16'h1357, 16'h0);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL idle_release_ready got=%b want=10", req_ready); end
    tick();
    total++; if (rsp_id !== 1'b1 || rsp_data !== 16'h1357) begin
      bad++; $display("FAIL idle_release_rsp got=%h/%h want=1/1357", rsp_id, rsp_data); end
    req_valid[1] = 1'b0;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL idle_req0_ready got=%b want=01", req_ready); end
    tick();
    clear_reqs();
    total++; if (rsp_id !== 1'b0 || rsp_data !== 16'h5555) begin
      bad++; $display("FAIL idle_req0_rsp got=%h/%h want=0/5555", rsp_id, rsp_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_chain();
    test_lock_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
